// File: rtl/maf_wb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : maf_wb
// Description : MAF result writeback FIFO with per-entry FP class flags,
//               issue credit tracking and sticky overflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module maf_wb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_vld,
    input  logic [31:0] res,
    input  logic        res_rdy,
    output logic        issue_ok,
    output logic        wb_vld,
    input  logic        wb_ack,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_flag,
    output logic        ovfl_err
);

    localparam int               c_aw       = $clog2(DEPTH);
    localparam logic [CNT_W:0]   c_depth    = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_infl_max = '1;
    localparam logic [c_aw-1:0]  c_ptr_one  = c_aw'(1);

    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [4:0]       flag_q [DEPTH];
    logic [4:0]       flag_d [DEPTH];
    logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic             ovfl_q, ovfl_d;

    logic [7:0]       w_exp;
    logic [22:0]      w_man;
    logic [4:0]       w_flag;
    logic             w_pop;
    logic             w_push;
    logic             w_full;

    // Outputs depend only on registered state, so a write never bypasses.
    always_comb begin
        wb_vld   = (count_q != '0);
        wb_data  = wb_vld ? data_q[rd_ptr_q] : '0;
        wb_flag  = wb_vld ? flag_q[rd_ptr_q] : '0;
        ovfl_err = ovfl_q;
        issue_ok = (({1'b0, count_q} + {1'b0, infl_q}) < c_depth);
    end

    always_comb begin
        w_exp  = res[30:23];
        w_man  = res[22:0];
        w_flag = {res[31],
                  (w_exp == 8'hFF) && (w_man != '0),
                  (w_exp == 8'hFF) && (w_man == '0),
                  (w_exp == 8'h00) && (w_man == '0),
                  (w_exp == 8'h00) && (w_man != '0)};

        w_pop  = wb_vld && wb_ack;
        w_full = ({1'b0, count_q} >= c_depth);
        w_push = res_rdy && (!w_full || w_pop);

        data_d   = data_q;
        flag_d   = flag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        infl_d   = infl_q;
        ovfl_d   = ovfl_q | (res_rdy & ~w_push);

        if (w_push) begin
            data_d[wr_ptr_q] = res;
            flag_d[wr_ptr_q] = w_flag;
            wr_ptr_d         = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (w_pop && !w_push) begin
            count_d = count_q - c_cnt_one;
        end

        // Credit counter saturates in both directions.
        if (op_vld && !res_rdy && (infl_q != c_infl_max)) begin
            infl_d = infl_q + c_cnt_one;
        end else if (res_rdy && !op_vld && (infl_q != '0)) begin
            infl_d = infl_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                flag_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            infl_q   <= '0;
            ovfl_q   <= 1'b0;
        end else begin
            data_q   <= data_d;
            flag_q   <= flag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            infl_q   <= infl_d;
            ovfl_q   <= ovfl_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maf_wb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_maf_wb
// Description : Scoreboard bench for maf_wb with directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maf_wb;

    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;
    localparam int INFL_MAX = 7;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        op_vld  = 1'b0;
    logic [31:0] res     = '0;
    logic        res_rdy = 1'b0;
    logic        wb_ack  = 1'b0;
    logic        issue_ok;
    logic        wb_vld;
    logic [31:0] wb_data;
    logic [4:0]  wb_flag;
    logic        ovfl_err;

    maf_wb #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_vld   (op_vld),
        .res      (res),
        .res_rdy  (res_rdy),
        .issue_ok (issue_ok),
        .wb_vld   (wb_vld),
        .wb_ack   (wb_ack),
        .wb_data  (wb_data),
        .wb_flag  (wb_flag),
        .ovfl_err (ovfl_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  f;
    } ent_t;

    ent_t        sb_q[$];
    logic [4:0]  flag_log[$];
    logic [31:0] data_log[$];
    int          m_count = 0;
    int          m_infl  = 0;
    bit          m_ovfl  = 1'b0;
    int          n_pass  = 0;
    int          n_total = 0;
    bit          mon_en  = 1'b0;

    function automatic logic [4:0] classify(input logic [31:0] v);
        int  e;
        int  m;
        e = int'(v[30:23]);
        m = int'(v[22:0]);
        return {v[31], (e == 255) && (m != 0), (e == 255) && (m == 0),
                (e == 0) && (m == 0), (e == 0) && (m != 0)};
    endfunction

    task automatic chk(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference behaviour of one clock edge, applied with the pre-edge model state.
    task automatic model_edge(input bit op, input bit rdy, input logic [31:0] d, input bit ack);
        bit pop;
        bit push;
        pop  = (m_count != 0) && ack;
        push = rdy && ((m_count < DEPTH) || pop);
        if (push) sb_q.push_back(ent_t'({d, classify(d)}));
        if (rdy && !push) m_ovfl = 1'b1;
        m_count = m_count + int'(push) - int'(pop);
        if (op && !rdy) m_infl = (m_infl < INFL_MAX) ? m_infl + 1 : INFL_MAX;
        else if (rdy && !op) m_infl = (m_infl > 0) ? m_infl - 1 : 0;
    endtask

    task automatic cyc(input bit op, input bit rdy, input logic [31:0] d, input bit ack);
        op_vld  = op;
        res_rdy = rdy;
        res     = d;
        wb_ack  = ack;
        @(posedge clk);
        #1;
        model_edge(op, rdy, d, ack);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            chk("wb_vld", wb_vld == (m_count != 0), 32'(wb_vld), 32'(m_count != 0));
            chk("issue_ok", issue_ok == ((m_count + m_infl) < DEPTH),
                32'(issue_ok), 32'((m_count + m_infl) < DEPTH));
            chk("ovfl_err", ovfl_err == m_ovfl, 32'(ovfl_err), 32'(m_ovfl));
            if (wb_vld) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_entry", 1'b0, wb_data, 32'h0);
                end else begin
                    chk("wb_data", wb_data == sb_q[0].d, wb_data, sb_q[0].d);
                    chk("wb_flag", wb_flag == sb_q[0].f, 32'(wb_flag), 32'(sb_q[0].f));
                    if (wb_ack) begin
                        flag_log.push_back(wb_flag);
                        data_log.push_back(wb_data);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [4:0]  exp_cls [4];
        logic [31:0] cls_val [4];
        logic [31:0] d;
        exp_cls = '{5'b01000, 5'b10100, 5'b10010, 5'b00001};
        cls_val = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00400000};

        #2;
        chk("rst_wb_vld", wb_vld == 1'b0, 32'(wb_vld), 32'h0);
        chk("rst_issue_ok", issue_ok == 1'b1, 32'(issue_ok), 32'h1);
        chk("rst_ovfl", ovfl_err == 1'b0, 32'(ovfl_err), 32'h0);
        chk("rst_wb_data", wb_data == 32'h0, wb_data, 32'h0);
        chk("rst_wb_flag", wb_flag == 5'h0, 32'(wb_flag), 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single op: result appears one cycle after res_rdy and is taken at once.
        data_log.delete();
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h41200000, 1);
        repeat (2) cyc(0, 0, 0, 1);
        chk("single_count", data_log.size() == 1, data_log.size(), 32'd1);
        if (data_log.size() == 1) begin
            chk("single_data", data_log[0] == 32'h41200000, data_log[0], 32'h41200000);
            chk("single_flag", flag_log[flag_log.size()-1] == 5'b00000,
                32'(flag_log[flag_log.size()-1]), 32'h0);
        end

        // Class flags in consecutive cycles.
        flag_log.delete();
        repeat (4) cyc(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, cls_val[i], 1);
        repeat (3) cyc(0, 0, 0, 1);
        chk("class_count", flag_log.size() == 4, flag_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < flag_log.size(); i++)
            chk("class_flag", flag_log[i] == exp_cls[i], 32'(flag_log[i]), 32'(exp_cls[i]));

        // Credit: four ops exhaust issue credit; one ack restores it.
        repeat (4) cyc(1, 0, 0, 0);
        chk("credit_exhausted", issue_ok == 1'b0, 32'(issue_ok), 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'hB0000000 + 32'(i), 0);
        chk("credit_full_fifo", issue_ok == 1'b0, 32'(issue_ok), 32'h0);
        cyc(0, 0, 0, 1);
        chk("credit_restored", issue_ok == 1'b1, 32'(issue_ok), 32'h1);
        repeat (4) cyc(0, 0, 0, 1);

        // Overflow: fifth result into a full FIFO is dropped and flagged.
        data_log.delete();
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'hA0000000 + 32'(i), 0);
        cyc(0, 1, 32'h12345678, 0);
        chk("ovfl_set", ovfl_err == 1'b1, 32'(ovfl_err), 32'h1);
        repeat (5) cyc(0, 0, 0, 1);
        chk("ovfl_drain_count", data_log.size() == 4, data_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < data_log.size(); i++)
            chk("ovfl_drain_data", data_log[i] == 32'hA0000000 + 32'(i),
                data_log[i], 32'hA0000000 + 32'(i));
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'hC0000000 + 32'(i), 0);
        cyc(0, 1, 32'hC0000004, 1);
        chk("full_pop_push_vld", wb_vld == 1'b1, 32'(wb_vld), 32'h1);
        chk("full_pop_push_ovfl", ovfl_err == 1'b1, 32'(ovfl_err), 32'h1);
        data_log.delete();
        repeat (5) cyc(0, 0, 0, 1);
        chk("full_pop_push_drain", data_log.size() == 4, data_log.size(), 32'd4);

        // Wrap: ten results with the ack toggling every cycle.
        data_log.delete();
        for (int i = 0; i < 20; i++)
            cyc(0, (i % 2) == 0, 32'hD0000000 + 32'(i / 2), (i % 2) == 1);
        repeat (2) cyc(0, 0, 0, 1);
        chk("wrap_count", data_log.size() == 10, data_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < data_log.size(); i++)
            chk("wrap_order", data_log[i] == 32'hD0000000 + 32'(i),
                data_log[i], 32'hD0000000 + 32'(i));

        // Reset mid-stream: two queued, one in flight, reset pulsed between edges.
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 1, 32'hE0000000, 0);
        cyc(0, 1, 32'hE0000001, 0);
        op_vld  = 1'b0;
        res_rdy = 1'b0;
        wb_ack  = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_vld", wb_vld == 1'b0, 32'(wb_vld), 32'h0);
        chk("midrst_issue_ok", issue_ok == 1'b1, 32'(issue_ok), 32'h1);
        chk("midrst_ovfl", ovfl_err == 1'b0, 32'(ovfl_err), 32'h0);
        chk("midrst_wb_data", wb_data == 32'h0, wb_data, 32'h0);
        m_count = 0;
        m_infl  = 0;
        m_ovfl  = 1'b0;
        sb_q.delete();
        #2;
        rst_n = 1'b1;
        data_log.delete();
        cyc(0, 1, 32'hF0000000, 0);
        chk("stale_accept", wb_vld == 1'b1, 32'(wb_vld), 32'h1);
        chk("stale_issue_ok", issue_ok == 1'b1, 32'(issue_ok), 32'h1);
        repeat (2) cyc(0, 0, 0, 1);
        chk("stale_drain", data_log.size() == 1, data_log.size(), 32'd1);

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            case ($urandom_range(0, 3))
                0: d[30:23] = 8'h00;
                1: d[30:23] = 8'hFF;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) d[22:0] = '0;
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, d,
                $urandom_range(0, 2) != 0);
        end
        repeat (6) cyc(0, 0, 0, 1);
        chk("sb_leftover", sb_q.size() == 0, sb_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
